dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester access controller for the single-port data RAM (word index = address>>2, combinational read).
//  Port A is the MIPS datapath load/store path; port B is the loader/debug port. The block holds off all
//  traffic during the RAM's post-reset preload cycles, picks a winner per cycle, and drives the one RAM port.
// PARAMETERS
//  size        64  RAM depth in 32-bit words; sets the bound for the range check
//  data_width  32  width of the data buses
//  MAX_WAIT    4   cycles B may be denied before B gets priority (>=1)
//  INIT_CYCLES 1   cycles after reset with no RAM access (covers the RAM preload cycle; >=1)
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   synchronous, active-high reset
//  a_req         in   1   A request; hold req/we/addr/wdata stable until a_ack
//  a_we          in   1   A: 1=write, 0=read
//  a_addr        in   32  A byte address
//  a_wdata       in   DW  A write data
//  a_ack         out  1   A access performed this cycle (Mealy)
//  a_rdata       out  DW  A read data; valid when a_ack & ~a_we
//  a_err         out  1   A access rejected (ACCESS_CHECK_EN only); valid with a_ack
//  b_req/b_we/b_addr/b_wdata/b_ack/b_rdata/b_err   same as A, for port B
//  ram_address   out  32  to RAM address
//  ram_data_write out DW  to RAM data_write
//  ram_write_en  out  1   to RAM write_en
//  ram_read_en   out  1   to RAM read_en
//  ram_data_out  in   DW  from RAM data_out
//  ready         out  1   1 once the INIT phase is over
// BEHAVIOUR
//  - FSM: INIT -> ARB. On reset: state=INIT, init_cnt=0, starve_cnt=0. INIT lasts INIT_CYCLES cycles,
//    then ARB. State stays ARB until the next reset. Reset at any time, including mid-access, returns to
//    INIT on the next edge. Any access in flight is dropped with no ack. The requester keeps req high.
//  - Output values in INIT and during reset: a_ack=b_ack=0, a_err=b_err=0, ram_write_en=0, ram_read_en=0,
//    ready=0, ram_address=0, ram_data_write=0, a_rdata=b_rdata=0.
//  - ARB winner selection, evaluated combinationally each cycle:
//    - If only one port requests, that port wins.
//    - If both request, A wins unless starve_cnt==MAX_WAIT, in which case B wins.
//  - Winner handling: the winner's addr and wdata are driven to the RAM.
//    - ram_write_en = winner we; ram_read_en = ~winner we.
//    - Winner ack=1 in the same cycle, so latency is 0 (the RAM read is combinational).
//    - Winner rdata = ram_data_out. The loser's ack=0 and its rdata=0.
//    - The RAM write commits at the clock edge that ends the ack cycle.
//  - No request: ram_read_en=0, ram_write_en=0, acks=0.
//  - starve_cnt, updated on each clock edge in ARB:
//    - Set to 0 if b_req=0 or b_ack=1.
//    - Otherwise incremented, saturating at MAX_WAIT.
//  - A stalled CPU sees a_req & ~a_ack. B can take at most 1 grant in every MAX_WAIT+1 contended cycles.
//  - Back-to-back: a port that still has req=1 after an ack is treated as a new request. It may win again
//    on the next cycle.
// CONFIGURATION
//  ACCESS_CHECK_EN defined:
//    - A winner with addr[1:0]!=0 or (addr>>2)>=size is acked with err=1 and rdata=0.
//    - For a rejected access, ram_write_en=0 and ram_read_en=0, so the RAM is untouched.
//    - A rejected access still consumes the grant and clears starve_cnt for B.
//  ACCESS_CHECK_EN undefined: err outputs are tied 0 and addresses pass unchecked to the RAM.
// TESTING
//  1. reset=1 for 2 cycles, then 0, with a_req=1 (read, addr 0) -> ready=0 and a_ack=0 for 1 cycle;
//     then a_ack=1 and a_rdata=32'h00000003.
//  2. A write addr 0x10 data 0xDEADBEEF, then A read addr 0x10 -> second access: a_ack=1,
//     a_rdata=0xDEADBEEF.
//  3. a_req and b_req both held high, MAX_WAIT=4 -> grant pattern A,A,A,A,B repeating; b_ack every
//     5th cycle.
//  4. Only b_req high, write addr 0x08 data 7 -> b_ack=1 the same cycle; a later A read of 0x08 returns 7.
//  5. Reset asserted during a B write cycle -> no ack; RAM word unchanged; ready=0 for INIT_CYCLES; then
//     normal operation.
//  6. ACCESS_CHECK_EN: A read addr 0x02 -> a_ack=1, a_err=1, ram_read_en=0.
//     A write addr 4*size -> a_err=1, ram_write_en=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: A = datapath, B = loader/debug.
// Optional range/alignment checking is enabled by defining ACCESS_CHECK_EN.
module dmem_arbiter #(
  parameter int size        = 64,
  parameter int data_width  = 32,
  parameter int MAX_WAIT    = 4,
  parameter int INIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [31:0]           a_addr,
  input  logic [data_width-1:0] a_wdata,
  output logic                  a_ack,
  output logic [data_width-1:0] a_rdata,
  output logic                  a_err,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [31:0]           b_addr,
  input  logic [data_width-1:0] b_wdata,
  output logic                  b_ack,
  output logic [data_width-1:0] b_rdata,
  output logic                  b_err,
  output logic [31:0]           ram_address,
  output logic [data_width-1:0] ram_data_write,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  input  logic [data_width-1:0] ram_data_out,
  output logic                  ready
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int SW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    INIT,
    ARB
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [data_width-1:0] wdata;
  } port_req_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   init_cnt;
  logic [IW-1:0]   init_cnt_nxt;
  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_nxt;

  logic      active;
  logic      starved;
  logic      grant_a;
  logic      grant_b;
  logic      granted;
  logic      sel_bad;
  port_req_t req_a;
  port_req_t req_b;
  port_req_t sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      init_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      init_cnt   <= init_cnt_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    unique case (state)
      INIT: begin
        if (init_cnt == IW'(INIT_CYCLES - 1))
          state_nxt = ARB;
        else
          init_cnt_nxt = init_cnt + 1'b1;
      end
      ARB:     state_nxt = ARB;
      default: state_nxt = INIT;
    endcase
  end

  // B's wait counter saturates; at the cap B overrides A's priority.
  always_comb begin
    starve_nxt = starve_cnt;
    if (state == ARB) begin
      if (!b_req || b_ack)
        starve_nxt = '0;
      else if (!starved)
        starve_nxt = starve_cnt + 1'b1;
    end
  end

  assign active  = (state == ARB) && !reset;
  assign starved = (starve_cnt == SW'(MAX_WAIT));
  assign grant_b = active && b_req && (!a_req || starved);
  assign grant_a = active && a_req && !grant_b;
  assign granted = grant_a || grant_b;

  assign req_a = '{we: a_we, addr: a_addr, wdata: a_wdata};
  assign req_b = '{we: b_we, addr: b_addr, wdata: b_wdata};

  always_comb begin
    sel = '0;
    unique case (1'b1)
      grant_a: sel = req_a;
      grant_b: sel = req_b;
      default: sel = '0;
    endcase
  end

`ifdef ACCESS_CHECK_EN
  assign sel_bad = granted &&
                   ((sel.addr[1:0] != 2'b00) ||
                    ((sel.addr >> 2) >= 32'(size)));
`else
  assign sel_bad = 1'b0;
`endif

  assign ram_address    = sel.addr;
  assign ram_data_write = sel.wdata;
  assign ram_write_en   = granted && sel.we && !sel_bad;
  assign ram_read_en    = granted && !sel.we && !sel_bad;
  assign ready          = active;

  assign a_ack   = grant_a;
  assign b_ack   = grant_b;
  assign a_err   = grant_a && sel_bad;
  assign b_err   = grant_b && sel_bad;
  assign a_rdata = (grant_a && !sel_bad) ? ram_data_out : '0;
  assign b_rdata = (grant_b && !sel_bad) ? ram_data_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM.
// Word 0 is preloaded with 3 on the first clock edge.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        a_req;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        a_err;
  logic        b_req;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        b_err;
  logic [31:0] ram_address;
  logic [31:0] ram_data_write;
  logic        ram_write_en;
  logic        ram_read_en;
  logic [31:0] ram_data_out;
  logic        ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];
  bit          loaded = 1'b0;

  dmem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .a_req          (a_req),
    .a_we           (a_we),
    .a_addr         (a_addr),
    .a_wdata        (a_wdata),
    .a_ack          (a_ack),
    .a_rdata        (a_rdata),
    .a_err          (a_err),
    .b_req          (b_req),
    .b_we           (b_we),
    .b_addr         (b_addr),
    .b_wdata        (b_wdata),
    .b_ack          (b_ack),
    .b_rdata        (b_rdata),
    .b_err          (b_err),
    .ram_address    (ram_address),
    .ram_data_write (ram_data_write),
    .ram_write_en   (ram_write_en),
    .ram_read_en    (ram_read_en),
    .ram_data_out   (ram_data_out),
    .ready          (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_data_out = mem[ram_address[7:2]];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h3;
      loaded <= 1'b1;
    end else if (ram_write_en) begin
      mem[ram_address[7:2]] <= ram_data_write;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc;
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    a_req   = 1'b1;
    a_we    = 1'b0;
    a_addr  = 32'h0;
    a_wdata = 32'h0;
    b_req   = 1'b0;
    b_we    = 1'b0;
    b_addr  = 32'h0;
    b_wdata = 32'h0;

    #2;
    chk("rst0_ready", 32'(ready), 32'd0);
    chk("rst0_a_ack", 32'(a_ack), 32'd0);
    chk("rst0_addr", ram_address, 32'd0);
    next_cyc(); #2;
    chk("rst1_a_ack", 32'(a_ack), 32'd0);
    chk("rst1_rden", 32'(ram_read_en), 32'd0);

    next_cyc();
    reset = 1'b0;
    #2;
    chk("init_ready", 32'(ready), 32'd0);
    chk("init_a_ack", 32'(a_ack), 32'd0);
    chk("init_a_rdata", a_rdata, 32'd0);

    next_cyc(); #2;
    chk("t1_ready", 32'(ready), 32'd1);
    chk("t1_a_ack", 32'(a_ack), 32'd1);
    chk("t1_a_rdata", a_rdata, 32'h3);
    chk("t1_rden", 32'(ram_read_en), 32'd1);

    next_cyc();
    a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
    #2;
    chk("t2w_a_ack", 32'(a_ack), 32'd1);
    chk("t2w_wren", 32'(ram_write_en), 32'd1);
    chk("t2w_rden", 32'(ram_read_en), 32'd0);
    chk("t2w_wdata", ram_data_write, 32'hDEADBEEF);
    next_cyc();
    a_we = 1'b0;
    #2;
    chk("t2r_a_ack", 32'(a_ack), 32'd1);
    chk("t2r_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("t2r_b_ack", 32'(b_ack), 32'd0);

    next_cyc();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h08; b_wdata = 32'h7;
    #2;
    chk("t4_b_ack", 32'(b_ack), 32'd1);
    chk("t4_a_ack", 32'(a_ack), 32'd0);
    chk("t4_addr", ram_address, 32'h08);
    next_cyc();
    b_req = 1'b0; b_we = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h08;
    #2;
    chk("t4_a_rdata", a_rdata, 32'h7);

    next_cyc();
    a_req = 1'b0;
    #2;
    chk("idle_a_ack", 32'(a_ack), 32'd0);
    chk("idle_b_ack", 32'(b_ack), 32'd0);
    chk("idle_rden", 32'(ram_read_en), 32'd0);
    chk("idle_wren", 32'(ram_write_en), 32'd0);

    next_cyc();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("t3_a_ack%0d", i), 32'(a_ack),
          (i % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("t3_b_ack%0d", i), 32'(b_ack),
          (i % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t3_b_rdata%0d", i), b_rdata,
          (i % 5 == 4) ? 32'hDEADBEEF : 32'd0);
      chk($sformatf("t3_addr%0d", i), ram_address,
          (i % 5 == 4) ? 32'h10 : 32'h0);
      next_cyc();
    end

    b_req = 1'b0;
    a_addr = 32'h02;
    #2;
`ifdef ACCESS_CHECK_EN
    chk("t6r_a_ack", 32'(a_ack), 32'd1);
    chk("t6r_a_err", 32'(a_err), 32'd1);
    chk("t6r_rden", 32'(ram_read_en), 32'd0);
    chk("t6r_a_rdata", a_rdata, 32'd0);
    next_cyc();
    a_we = 1'b1; a_addr = 32'h100; a_wdata = 32'h1234;
    #2;
    chk("t6w_a_err", 32'(a_err), 32'd1);
    chk("t6w_wren", 32'(ram_write_en), 32'd0);
`else
    chk("t6r_a_ack", 32'(a_ack), 32'd1);
    chk("t6r_a_err", 32'(a_err), 32'd0);
    chk("t6r_rden", 32'(ram_read_en), 32'd1);
    chk("t6r_a_rdata", a_rdata, 32'h3);
`endif

    next_cyc();
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h08; b_wdata = 32'h55;
    reset = 1'b1;
    #2;
    chk("t5_rst_b_ack", 32'(b_ack), 32'd0);
    chk("t5_rst_wren", 32'(ram_write_en), 32'd0);
    next_cyc();
    reset = 1'b0;
    #2;
    chk("t5_init_ready", 32'(ready), 32'd0);
    chk("t5_init_b_ack", 32'(b_ack), 32'd0);
    chk("t5_mem_kept", mem[2], 32'h7);
    next_cyc(); #2;
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_b_ack", 32'(b_ack), 32'd1);
    next_cyc();
    b_req = 1'b0; b_we = 1'b0;
    a_req = 1'b1; a_addr = 32'h08;
    #2;
    chk("t5_a_rdata", a_rdata, 32'h55);

    next_cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
